mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max ACCESS cycles awaiting DmemAck before abort (1..255).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cHazard  in  1  flush of incoming EX/MEM slot.
REQ-005 ALUOutIn  in  32  ALU result / effective address from EX/MEM.
REQ-006 RdDataBIn  in  32  store data from EX/MEM.
REQ-007 WrNumIn  in  5  destination register number.
REQ-008 RfWrEnableIn, IsLoadInsnIn, IsStoreInsnIn  in  1 each  control from EX/MEM.
REQ-009 DmemReq  out  1  data-memory request, held until ack.
REQ-010 DmemWe  out  1  1 = write, 0 = read; valid with DmemReq.
REQ-011 DmemAddr, DmemWrData  out  32 each  address / write data; valid with DmemReq.
REQ-012 DmemAck  in  1  one-cycle completion from memory; DmemRdData valid same cycle.
REQ-013 DmemRdData  in  32  load data.
REQ-014 WbDataOut  out  32  MEM/WB register: write-back data.
REQ-015 WrNumOut  out  5  MEM/WB register: destination number.
REQ-016 RfWrEnableOut  out  1  MEM/WB register: register-file write enable.
REQ-017 BusErrOut  out  1  one-cycle registered pulse: misaligned access or timeout.
REQ-018 Stall  out  1  combinational; upstream pipeline holds EX/MEM while 1.

Function
REQ-019 FSM states SHALL be IDLE and ACCESS only.
REQ-020 MemOp = (IsLoadInsnIn | IsStoreInsnIn) & !cHazard; Aligned = ALUOutIn[1:0]==0.
REQ-021 IDLE, !MemOp: next edge WbDataOut<=ALUOutIn, WrNumOut<=WrNumIn, RfWrEnableOut<=RfWrEnableIn & !cHazard; Stall=0; latency 1 cycle.
REQ-022 IDLE, MemOp & Aligned: Stall=1; next edge capture address, store data, WrNumIn, RfWrEnableIn, load/store kind; RfWrEnableOut<=0 (bubble); go ACCESS.
REQ-023 IDLE, MemOp & !Aligned: no request, Stall=0, next edge RfWrEnableOut<=0, BusErrOut<=1.
REQ-024 IsLoadInsnIn and IsStoreInsnIn both 1: treat as store; no register write.
REQ-025 ACCESS: DmemReq=1, DmemWe/DmemAddr/DmemWrData driven from captured registers, constant until ack or abort.
REQ-026 ACCESS, DmemAck=1: Stall=0 that cycle; next edge go IDLE; load: WbDataOut<=DmemRdData, WrNumOut<=captured, RfWrEnableOut<=captured enable; store: RfWrEnableOut<=0.
REQ-027 ACCESS, DmemAck=0: Stall=1; wait counter increments (8 bits).
REQ-028 Counter reaching TIMEOUT_CYCLES without ack: Stall=0 that cycle; next edge go IDLE, BusErrOut<=1, RfWrEnableOut<=0; counter cleared on every ACCESS entry.
REQ-029 cHazard SHALL be ignored in ACCESS; in-flight transaction always completes or times out.
REQ-030 DmemAck in IDLE SHALL be ignored.
REQ-031 DmemReq SHALL be 0 in IDLE; a new request requires re-entering ACCESS (minimum one IDLE cycle between requests).
REQ-032 BusErrOut SHALL return to 0 on the edge after any pulse.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, counter 0, DmemReq=0, DmemWe=0, DmemAddr=0, DmemWrData=0, WbDataOut=0, WrNumOut=0, RfWrEnableOut=0, BusErrOut=0, Stall=0 (inputs idle), independent of clk.
REQ-034 Reset asserted in ACCESS SHALL drop DmemReq the same cycle; no write-back of the aborted op.

Verification
REQ-035 ALU op ALUOutIn=0x1234, WrNumIn=5, RfWrEnableIn=1 -> next cycle WbDataOut=0x1234, WrNumOut=5, RfWrEnableOut=1, Stall=0 throughout.
REQ-036 Load addr 0x100, WrNumIn=8, ack 3 cycles after DmemReq rises with DmemRdData=0xCAFEF00D -> Stall=1 for 4 cycles, DmemAddr=0x100, DmemWe=0, then WbDataOut=0xCAFEF00D, WrNumOut=8, RfWrEnableOut=1.
REQ-037 Store addr 0x200 data 0xDEADBEEF, immediate ack -> DmemWe=1, DmemWrData=0xDEADBEEF for one cycle, RfWrEnableOut=0, Stall=1 for exactly 1 cycle.
REQ-038 Load addr 0x103 -> no DmemReq, BusErrOut=1 for one cycle, RfWrEnableOut=0; TIMEOUT_CYCLES=4, never ack -> DmemReq high 5 cycles then 0, BusErrOut pulse, Stall released.
REQ-039 cHazard=1 with load in IDLE -> no DmemReq, RfWrEnableOut=0; cHazard=1 during ACCESS -> request completes normally.
REQ-040 rst=0 mid-ACCESS -> DmemReq=0 asynchronously, all outputs 0; after release a fresh load completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: forwards ALU results to MEM/WB, or runs one data-memory
// transaction (load/store) with alignment check and ack timeout.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cHazard,
   input  logic [31:0] ALUOutIn,
   input  logic [31:0] RdDataBIn,
   input  logic [4:0]  WrNumIn,
   input  logic        RfWrEnableIn,
   input  logic        IsLoadInsnIn,
   input  logic        IsStoreInsnIn,
   output logic        DmemReq,
   output logic        DmemWe,
   output logic [31:0] DmemAddr,
   output logic [31:0] DmemWrData,
   input  logic        DmemAck,
   input  logic [31:0] DmemRdData,
   output logic [31:0] WbDataOut,
   output logic [4:0]  WrNumOut,
   output logic        RfWrEnableOut,
   output logic        BusErrOut,
   output logic        Stall,
   output logic        DbgState
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_wr_num;
   logic        r_wr_en;
   logic        r_is_store;
   logic [31:0] r_wb_data;
   logic [4:0]  r_wb_num;
   logic        r_wb_en;
   logic        r_bus_err;

   logic        w_mem_op;
   logic        w_aligned;
   logic        w_timeout;

   assign w_mem_op  = (IsLoadInsnIn | IsStoreInsnIn) & ~cHazard;
   assign w_aligned = (ALUOutIn[1:0] == 2'b00);
   assign w_timeout = (r_cnt == TIMEOUT_LIMIT);

   // Memory handshake: DmemReq is high for the whole ACCESS state with
   // address/we/data held constant; a single-cycle DmemAck (with DmemRdData)
   // completes it, and DmemReq drops on the following edge.
   assign DmemReq    = (r_state == ACCESS);
   assign DmemWe     = (r_state == ACCESS) ? r_is_store : 1'b0;
   assign DmemAddr   = (r_state == ACCESS) ? r_addr : 32'd0;
   assign DmemWrData = (r_state == ACCESS) ? r_wdata : 32'd0;
   assign DbgState   = (r_state == ACCESS);

   assign WbDataOut     = r_wb_data;
   assign WrNumOut      = r_wb_num;
   assign RfWrEnableOut = r_wb_en;
   assign BusErrOut     = r_bus_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      Stall  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_mem_op && w_aligned) begin
               Stall  = 1'b1;
               w_next = ACCESS;
            end
         end
         ACCESS: begin
            // cHazard is deliberately not looked at: the in-flight op finishes.
            if (DmemAck || w_timeout) w_next = IDLE;
            else                      Stall  = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= 8'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_wr_num   <= 5'd0;
         r_wr_en    <= 1'b0;
         r_is_store <= 1'b0;
         r_wb_data  <= 32'd0;
         r_wb_num   <= 5'd0;
         r_wb_en    <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_mem_op) begin
                  r_wb_data <= ALUOutIn;
                  r_wb_num  <= WrNumIn;
                  r_wb_en   <= RfWrEnableIn & ~cHazard;
               end else if (w_aligned) begin
                  r_addr     <= ALUOutIn;
                  r_wdata    <= RdDataBIn;
                  r_wr_num   <= WrNumIn;
                  r_wr_en    <= RfWrEnableIn;
                  r_is_store <= IsStoreInsnIn;
                  r_cnt      <= 8'd0;
                  r_wb_en    <= 1'b0;
               end else begin
                  r_wb_en   <= 1'b0;
                  r_bus_err <= 1'b1;
               end
            end
            ACCESS: begin
               if (DmemAck) begin
                  // A load+store combination was captured as a store: no write-back.
                  if (!r_is_store) begin
                     r_wb_data <= DmemRdData;
                     r_wb_num  <= r_wr_num;
                     r_wb_en   <= r_wr_en;
                  end else begin
                     r_wb_en <= 1'b0;
                  end
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_wb_en   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus a randomized instruction
// stream checked against a transaction-level model with a bench-side memory.
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cHazard;
   logic [31:0] ALUOutIn, RdDataBIn;
   logic [4:0]  WrNumIn;
   logic        RfWrEnableIn, IsLoadInsnIn, IsStoreInsnIn;
   logic        DmemReq, DmemWe;
   logic [31:0] DmemAddr, DmemWrData;
   logic        DmemAck;
   logic [31:0] DmemRdData;
   logic [31:0] WbDataOut;
   logic [4:0]  WrNumOut;
   logic        RfWrEnableOut, BusErrOut, Stall, DbgState;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .cHazard(cHazard),
      .ALUOutIn(ALUOutIn), .RdDataBIn(RdDataBIn), .WrNumIn(WrNumIn),
      .RfWrEnableIn(RfWrEnableIn), .IsLoadInsnIn(IsLoadInsnIn), .IsStoreInsnIn(IsStoreInsnIn),
      .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWrData(DmemWrData),
      .DmemAck(DmemAck), .DmemRdData(DmemRdData),
      .WbDataOut(WbDataOut), .WrNumOut(WrNumOut), .RfWrEnableOut(RfWrEnableOut),
      .BusErrOut(BusErrOut), .Stall(Stall), .DbgState(DbgState)
   );

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic drive_idle();
      cHazard = 1'b0; ALUOutIn = '0; RdDataBIn = '0; WrNumIn = '0;
      RfWrEnableIn = 1'b0; IsLoadInsnIn = 1'b0; IsStoreInsnIn = 1'b0;
      DmemAck = 1'b0; DmemRdData = '0;
   endtask

   // Presents one instruction, holds it while Stall is high, acts as the memory
   // (ack after `lat` request cycles; lat > TO means never), then checks MEM/WB.
   task automatic run_instr(input logic haz, input logic [31:0] alu, input logic [31:0] bdata,
                            input logic [4:0] wn, input logic en, input logic ld, input logic st,
                            input int lat, output int n_stall, output int n_req);
      logic mem_op, aligned, chk_data, exp_en, exp_err;
      logic [31:0] ld_data, exp_wb;
      int exp_stall, cyc;
      bit done;
      mem_op    = (ld | st) & ~haz;
      aligned   = (alu[1:0] == 2'b00);
      exp_stall = (mem_op && aligned) ? 1 + ((lat < TO) ? lat : TO) : 0;
      ld_data   = mem_read(alu);
      n_stall = 0; n_req = 0; cyc = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         n_checks++;
         if (DmemReq !== (cyc != 0) || DbgState !== (cyc != 0)) begin
            n_fail++;
            $display("FAIL dmem_req cyc=%0d: got req=%0b dbg=%0b expected %0b", cyc, DmemReq, DbgState, cyc != 0);
         end
         if (cyc >= 1) begin
            n_checks++;
            if (BusErrOut !== 1'b0) begin
               n_fail++;
               $display("FAIL buserr_pulse cyc=%0d: got %0b expected 0", cyc, BusErrOut);
            end
         end
         ALUOutIn = alu; RdDataBIn = bdata; WrNumIn = wn;
         RfWrEnableIn = en; IsLoadInsnIn = ld; IsStoreInsnIn = st;
         cHazard = (cyc == 0) ? haz : 1'($urandom_range(0, 1));
         if (DmemReq) begin
            n_checks++;
            if (DmemAddr !== alu || DmemWe !== st || (st && DmemWrData !== bdata)) begin
               n_fail++;
               $display("FAIL dmem_bus: got addr=%h we=%0b wd=%h expected addr=%h we=%0b wd=%h",
                        DmemAddr, DmemWe, DmemWrData, alu, st, bdata);
            end
            DmemAck = (n_req == lat);
            DmemRdData = ld_data;
            n_req++;
         end else begin
            DmemAck = ($urandom_range(0, 3) == 0);
            DmemRdData = $urandom;
         end
         #1;
         if (Stall) n_stall++;
         else       done = 1;
         cyc++;
         if (cyc > 40) begin
            n_checks++; n_fail++;
            $display("FAIL stall_bound: stall still high after %0d cycles expected release", cyc);
            done = 1;
         end
      end
      @(posedge clk);
      #1;
      DmemAck = 1'b0;
      chk_data = 1'b0; exp_wb = alu; exp_en = 1'b0; exp_err = 1'b0;
      if (!mem_op) begin
         exp_en = en & ~haz; chk_data = 1'b1;
      end else if (!aligned || lat > TO) begin
         exp_err = 1'b1;
      end else if (st) begin
         mem[alu] = bdata;
      end else begin
         exp_en = en; exp_wb = ld_data; chk_data = 1'b1;
      end
      n_checks++;
      if (n_stall != exp_stall) begin
         n_fail++;
         $display("FAIL stall_cycles: got %0d expected %0d", n_stall, exp_stall);
      end
      n_checks++;
      if (RfWrEnableOut !== exp_en || BusErrOut !== exp_err) begin
         n_fail++;
         $display("FAIL retire_ctrl addr=%h: got en=%0b err=%0b expected en=%0b err=%0b",
                  alu, RfWrEnableOut, BusErrOut, exp_en, exp_err);
      end
      if (chk_data) begin
         n_checks++;
         if (WbDataOut !== exp_wb || WrNumOut !== wn) begin
            n_fail++;
            $display("FAIL retire_data: got wb=%h num=%0d expected wb=%h num=%0d", WbDataOut, WrNumOut, exp_wb, wn);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_idle();
      #1;
      n_checks++;
      if ({DmemReq, DmemWe, DmemAddr, DmemWrData, WbDataOut, WrNumOut, RfWrEnableOut, BusErrOut, Stall, DbgState} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got req=%0b wb=%h num=%0d en=%0b err=%0b stall=%0b expected all 0",
                  DmemReq, WbDataOut, WrNumOut, RfWrEnableOut, BusErrOut, Stall);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_alu_op();
      int ns, nr;
      run_instr(1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, ns, nr);
      n_checks++;
      if (WbDataOut !== 32'h1234 || WrNumOut !== 5'd5 || RfWrEnableOut !== 1'b1 || ns != 0) begin
         n_fail++;
         $display("FAIL alu_op: got wb=%h num=%0d en=%0b stalls=%0d expected 1234/5/1/0", WbDataOut, WrNumOut, RfWrEnableOut, ns);
      end
   endtask

   task automatic test_load();
      int ns, nr;
      mem[32'h100] = 32'hCAFEF00D;
      run_instr(1'b0, 32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3, ns, nr);
      n_checks++;
      if (WbDataOut !== 32'hCAFEF00D || WrNumOut !== 5'd8 || RfWrEnableOut !== 1'b1 || ns != 4 || nr != 4) begin
         n_fail++;
         $display("FAIL load: got wb=%h num=%0d en=%0b stalls=%0d reqs=%0d expected cafef00d/8/1/4/4",
                  WbDataOut, WrNumOut, RfWrEnableOut, ns, nr);
      end
   endtask

   task automatic test_store();
      int ns, nr;
      run_instr(1'b0, 32'h200, 32'hDEADBEEF, 5'd9, 1'b1, 1'b0, 1'b1, 0, ns, nr);
      n_checks++;
      if (RfWrEnableOut !== 1'b0 || ns != 1 || nr != 1 || mem[32'h200] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL store: got en=%0b stalls=%0d reqs=%0d expected 0/1/1", RfWrEnableOut, ns, nr);
      end
      // load+store together behaves as a store
      run_instr(1'b0, 32'h204, 32'h5A5A0001, 5'd10, 1'b1, 1'b1, 1'b1, 1, ns, nr);
   endtask

   task automatic test_misaligned();
      int ns, nr;
      run_instr(1'b0, 32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, ns, nr);
      n_checks++;
      if (BusErrOut !== 1'b1 || RfWrEnableOut !== 1'b0 || nr != 0 || ns != 0) begin
         n_fail++;
         $display("FAIL misaligned: got err=%0b en=%0b reqs=%0d stalls=%0d expected 1/0/0/0", BusErrOut, RfWrEnableOut, nr, ns);
      end
      @(negedge clk);
      drive_idle();
      @(posedge clk); #1;
      n_checks++;
      if (BusErrOut !== 1'b0) begin
         n_fail++;
         $display("FAIL buserr_clear: got %0b expected 0", BusErrOut);
      end
   endtask

   task automatic test_timeout();
      int ns, nr;
      run_instr(1'b0, 32'h300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1000, ns, nr);
      n_checks++;
      if (nr != 5 || BusErrOut !== 1'b1 || RfWrEnableOut !== 1'b0 || ns != 5) begin
         n_fail++;
         $display("FAIL timeout: got reqs=%0d err=%0b en=%0b stalls=%0d expected 5/1/0/5", nr, BusErrOut, RfWrEnableOut, ns);
      end
   endtask

   task automatic test_hazard();
      int ns, nr;
      run_instr(1'b1, 32'h400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 0, ns, nr);
      n_checks++;
      if (nr != 0 || RfWrEnableOut !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_idle: got reqs=%0d en=%0b expected 0/0", nr, RfWrEnableOut);
      end
      // random cHazard toggling is applied during every ACCESS cycle of run_instr
      run_instr(1'b0, 32'h404, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2, ns, nr);
      n_checks++;
      if (RfWrEnableOut !== 1'b1 || WrNumOut !== 5'd12 || nr != 3) begin
         n_fail++;
         $display("FAIL hazard_access: got en=%0b num=%0d reqs=%0d expected 1/12/3", RfWrEnableOut, WrNumOut, nr);
      end
   endtask

   task automatic test_reset_mid_access();
      int ns, nr;
      @(negedge clk);
      drive_idle();
      ALUOutIn = 32'h40; WrNumIn = 5'd3; RfWrEnableIn = 1'b1; IsLoadInsnIn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (DmemReq !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_access_req: got %0b expected 1", DmemReq);
      end
      #2 rst = 1'b0;
      #1;
      drive_idle();
      #1;
      n_checks++;
      if ({DmemReq, DmemWe, DmemAddr, DmemWrData, WbDataOut, WrNumOut, RfWrEnableOut, BusErrOut, Stall, DbgState} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got req=%0b addr=%h wb=%h en=%0b stall=%0b expected all 0",
                  DmemReq, DmemAddr, WbDataOut, RfWrEnableOut, Stall);
      end
      @(negedge clk);
      rst = 1'b1;
      run_instr(1'b0, 32'h44, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1, ns, nr);
   endtask

   task automatic test_random();
      int ns, nr, kind;
      logic [31:0] addr;
      for (int i = 0; i < 250; i++) begin
         kind = $urandom_range(0, 3);
         addr = {24'h0, 3'($urandom_range(0, 7)), 5'd0} | 32'($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
         addr[4:2] = 3'($urandom_range(0, 7));
         run_instr(1'($urandom_range(0, 5) == 0), (kind == 0) ? $urandom : addr, $urandom,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   kind == 1 || kind == 3, kind == 2 || kind == 3, $urandom_range(0, TO + 2), ns, nr);
      end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load();
      test_store();
      test_misaligned();
      test_timeout();
      test_hazard();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
